action_interrupt_responder: RTL and testbench

Host-side endpoint for action interrupts. It receives single-cycle `interrupt_req` pulses with source and context from an action's kernel helper and buffers them. It forwards each one as a command to the host interrupt command channel, retries when the host reports failure, and returns a one-cycle `interrupt_ack` to the action when each interrupt is retired. It sits in the infrastructure between the action wrapper and the host command/response logic.

---
 rtl/action_interrupt_responder.sv | 134 +++++++++++++
 tb/tb_action_interrupt_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/action_interrupt_responder.sv
// Buffers action interrupt pulses and forwards them one at a time to the host
// interrupt command channel, retrying failed deliveries and acking each retirement.
module action_interrupt_responder #(
  parameter int CTXW       = 9,
  parameter int SRC_W      = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_RETRY  = 3,
  parameter int RETRY_GAP  = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             interrupt_req,
  input  logic [SRC_W-1:0] interrupt_src,
  input  logic [CTXW-1:0]  interrupt_ctx,
  output logic             interrupt_ack,
  output logic             intr_cmd_valid,
  input  logic             intr_cmd_ready,
  output logic [SRC_W-1:0] intr_cmd_src,
  output logic [CTXW-1:0]  intr_cmd_ctx,
  input  logic             intr_rsp_valid,
  input  logic             intr_rsp_failed,
  output logic             intr_pending,
  output logic             intr_drop,
  output logic             intr_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int BW = $clog2(RETRY_GAP + 1);

  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic [CTXW-1:0]  ctx;
  } intr_t;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_RSP, BACKOFF, RETIRE} state_t;

  state_t         state, state_nx;
  intr_t          mem [FIFO_DEPTH];
  intr_t          head;
  logic [PW-1:0]  wptr, rptr;
  logic [CW-1:0]  count;
  logic [RW-1:0]  rcnt, rcnt_nx;
  logic [BW-1:0]  bcnt, bcnt_nx;
  logic           full, empty, push, pop, err_set;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = (state == RETIRE);
  // A full FIFO still accepts when the head retires in the same cycle.
  assign push  = interrupt_req && (!full || pop);
  assign head  = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{src: interrupt_src, ctx: interrupt_ctx};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    rcnt_nx  = rcnt;
    bcnt_nx  = bcnt;
    err_set  = 1'b0;
    case (state)
      IDLE: begin
        rcnt_nx = '0;
        if (!empty) state_nx = SEND;
      end
      SEND: if (intr_cmd_ready) state_nx = WAIT_RSP;
      WAIT_RSP: begin
        if (intr_rsp_valid) begin
          if (!intr_rsp_failed) begin
            state_nx = RETIRE;
          end else if (rcnt < RW'(MAX_RETRY)) begin
            rcnt_nx  = rcnt + 1'b1;
            bcnt_nx  = '0;
            state_nx = BACKOFF;
          end else begin
            err_set  = 1'b1;
            state_nx = RETIRE;
          end
        end
      end
      BACKOFF: begin
        if (bcnt == BW'(RETRY_GAP - 1)) state_nx = SEND;
        else                            bcnt_nx  = bcnt + 1'b1;
      end
      RETIRE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      rcnt           <= '0;
      bcnt           <= '0;
      interrupt_ack  <= 1'b0;
      intr_cmd_valid <= 1'b0;
      intr_cmd_src   <= '0;
      intr_cmd_ctx   <= '0;
      intr_pending   <= 1'b0;
      intr_drop      <= 1'b0;
      intr_err       <= 1'b0;
    end else begin
      state          <= state_nx;
      rcnt           <= rcnt_nx;
      bcnt           <= bcnt_nx;
      interrupt_ack  <= (state_nx == RETIRE) && (state == WAIT_RSP);
      intr_err       <= err_set;
      intr_cmd_valid <= (state_nx == SEND);
      intr_cmd_src   <= (state_nx == SEND) ? head.src : '0;
      intr_cmd_ctx   <= (state_nx == SEND) ? head.ctx : '0;
      intr_pending   <= !empty || (state != IDLE);
      intr_drop      <= interrupt_req && !push;
    end
  end
endmodule

// File: tb/tb_action_interrupt_responder.sv
// Randomized bench for action_interrupt_responder with a queue-based reference
// model and a negedge monitor acting as scoreboard.
module tb_action_interrupt_responder;
  localparam int CTXW = 9, SRC_W = 64, DEPTH = 4, MAXR = 3, GAP = 16;

  logic             clk = 1'b0, resetn = 1'b0;
  logic             interrupt_req = 1'b0;
  logic [SRC_W-1:0] interrupt_src = '0;
  logic [CTXW-1:0]  interrupt_ctx = '0;
  logic             interrupt_ack, intr_cmd_valid, intr_pending, intr_drop, intr_err;
  logic             intr_cmd_ready = 1'b0, intr_rsp_valid = 1'b0, intr_rsp_failed = 1'b0;
  logic [SRC_W-1:0] intr_cmd_src;
  logic [CTXW-1:0]  intr_cmd_ctx;

  action_interrupt_responder #(.CTXW(CTXW), .SRC_W(SRC_W), .FIFO_DEPTH(DEPTH),
    .MAX_RETRY(MAXR), .RETRY_GAP(GAP)) dut (
    .clk(clk), .resetn(resetn), .interrupt_req(interrupt_req),
    .interrupt_src(interrupt_src), .interrupt_ctx(interrupt_ctx),
    .interrupt_ack(interrupt_ack), .intr_cmd_valid(intr_cmd_valid),
    .intr_cmd_ready(intr_cmd_ready), .intr_cmd_src(intr_cmd_src),
    .intr_cmd_ctx(intr_cmd_ctx), .intr_rsp_valid(intr_rsp_valid),
    .intr_rsp_failed(intr_rsp_failed), .intr_pending(intr_pending),
    .intr_drop(intr_drop), .intr_err(intr_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [SRC_W-1:0] src;
    logic [CTXW-1:0]  ctx;
  } ent_t;

  ent_t pend[$];
  int   checks = 0, errors = 0, cyc = 0;
  int   sends = 0, exp_rise = -1, exp_ack = -1, sz_d1 = 0, sz_d2 = 0;
  bit   outstanding = 0, exp_err = 0, exp_drop = 0, prev_valid = 0, prev_ready = 0;
  bit   ack_now, rise, acc, was_empty;
  logic [SRC_W-1:0] prev_src;
  logic [CTXW-1:0]  prev_ctx;

  int ready_pct = 100, fail_pct = 0, rsp_fix = -1;
  bit spur_en = 0, fail_once = 0, rsp_sched = 0;
  int rsp_dly = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Scoreboard / reference model: one pass per cycle on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      pend.delete();
      outstanding = 0; sends = 0; exp_rise = -1; exp_ack = -1; exp_err = 0;
      exp_drop = 0; prev_valid = 0; prev_ready = 0; sz_d1 = 0; sz_d2 = 0;
    end else begin
      chk("drop", 64'(intr_drop), 64'(exp_drop));
      ack_now = (cyc == exp_ack);
      chk("ack", 64'(interrupt_ack), 64'(ack_now));
      chk("err", 64'(intr_err), 64'(ack_now && exp_err));
      if (ack_now && exp_err) chk("sends_at_err", 64'(sends), 64'(MAXR + 1));
      chk("pending", 64'(intr_pending), 64'(sz_d2 > 0));
      rise = intr_cmd_valid && !prev_valid;
      if (rise || cyc == exp_rise) chk("cmd_rise", 64'(rise), 64'(cyc == exp_rise));
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", 64'(intr_cmd_valid), 64'd1);
        chk("hold_src", intr_cmd_src, prev_src);
        chk("hold_ctx", 64'(intr_cmd_ctx), 64'(prev_ctx));
      end
      if (!intr_cmd_valid) begin
        chk("idle_src", intr_cmd_src, 64'd0);
        chk("idle_ctx", 64'(intr_cmd_ctx), 64'd0);
      end
      if (intr_rsp_valid && outstanding) begin
        outstanding = 0;
        if (!intr_rsp_failed || sends == MAXR + 1) begin
          exp_ack = cyc + 1;
          exp_err = intr_rsp_failed;
        end else begin
          exp_rise = cyc + GAP + 1;
        end
      end
      if (intr_cmd_valid && intr_cmd_ready) begin
        if (pend.size() == 0) chk("hs_unexpected", 64'd1, 64'd0);
        else begin
          chk("cmd_src", intr_cmd_src, pend[0].src);
          chk("cmd_ctx", 64'(intr_cmd_ctx), 64'(pend[0].ctx));
        end
        sends++;
        chk("send_limit", 64'(sends <= MAXR + 1), 64'd1);
        outstanding = 1;
      end
      if (ack_now) begin
        if (pend.size() > 0) void'(pend.pop_front());
        sends = 0;
      end
      was_empty = (pend.size() == 0);
      acc = 0;
      if (interrupt_req && pend.size() < DEPTH) begin
        pend.push_back('{src: interrupt_src, ctx: interrupt_ctx});
        acc = 1;
      end
      exp_drop = interrupt_req && !acc;
      if ((ack_now || (acc && was_empty)) && pend.size() > 0) exp_rise = cyc + 2;
      prev_valid = intr_cmd_valid; prev_ready = intr_cmd_ready;
      prev_src = intr_cmd_src; prev_ctx = intr_cmd_ctx;
      sz_d2 = sz_d1; sz_d1 = pend.size();
    end
  end

  task automatic drive(input bit do_req, input logic [SRC_W-1:0] s, input logic [CTXW-1:0] c);
    @(posedge clk); #1;
    interrupt_req   = do_req;
    interrupt_src   = s;
    interrupt_ctx   = c;
    intr_cmd_ready  = ($urandom_range(99) < ready_pct);
    intr_rsp_valid  = 1'b0;
    intr_rsp_failed = 1'($urandom_range(1));
    if (outstanding && !rsp_sched) begin
      rsp_sched = 1;
      rsp_dly   = (rsp_fix >= 0) ? rsp_fix : int'($urandom_range(3));
    end
    if (rsp_sched) begin
      if (rsp_dly == 0) begin
        intr_rsp_valid  = 1'b1;
        intr_rsp_failed = fail_once || ($urandom_range(99) < fail_pct);
        fail_once = 0;
        rsp_sched = 0;
      end else rsp_dly--;
    end else if (spur_en && !outstanding && $urandom_range(15) == 0) begin
      intr_rsp_valid = 1'b1;
    end
  endtask

  task automatic run(input int n, input int rq_pct);
    repeat (n) drive($urandom_range(99) < rq_pct, {$urandom, $urandom}, 9'($urandom));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ack"},   64'(interrupt_ack), 64'd0);
    chk({tag, "_valid"}, 64'(intr_cmd_valid), 64'd0);
    chk({tag, "_src"},   intr_cmd_src, 64'd0);
    chk({tag, "_ctx"},   64'(intr_cmd_ctx), 64'd0);
    chk({tag, "_pend"},  64'(intr_pending), 64'd0);
    chk({tag, "_drop"},  64'(intr_drop), 64'd0);
    chk({tag, "_err"},   64'(intr_err), 64'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 check_zero("rst");
    @(posedge clk); #1 resetn = 1'b1;

    // Single interrupt, immediate ready, done 3 cycles after handshake
    ready_pct = 100; fail_pct = 0; rsp_fix = 2;
    drive(1, 64'h0000_0001_0000_0004, 9'h005);
    run(12, 0);

    // Backpressure
    ready_pct = 0;
    drive(1, 64'hdead_beef_0123_4567, 9'h1a5);
    run(12, 0);
    ready_pct = 100;
    run(10, 0);

    // Retry then success
    fail_once = 1;
    drive(1, 64'h55, 9'h055);
    run(40, 0);

    // Retry exhaustion
    fail_pct = 100;
    drive(1, 64'h77, 9'h077);
    run(4 * (GAP + 6), 0);
    fail_pct = 0;

    // Overflow and ordering
    ready_pct = 0;
    for (int i = 1; i <= 5; i++) drive(1, 64'(i), 9'(i));
    run(3, 0);
    ready_pct = 100;
    run(40, 0);

    // Randomized traffic
    ready_pct = 60; fail_pct = 30; rsp_fix = -1; spur_en = 1;
    run(2000, 30);
    run(4 * DEPTH * (GAP + 8), 0);

    // Reset while waiting for a response with two entries buffered
    ready_pct = 100; fail_pct = 0; rsp_fix = 30; spur_en = 0;
    drive(1, 64'haa, 9'h0aa);
    drive(1, 64'hbb, 9'h0bb);
    n = 0;
    while (!(outstanding && pend.size() == 2) && n < 20) begin drive(0, '0, '0); n++; end
    chk("reach_wait_rsp", 64'(n < 20), 64'd1);
    @(posedge clk); #1 resetn = 1'b0; interrupt_req = 1'b0; rsp_sched = 0;
    #1 check_zero("midrst");
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    rsp_fix = -1;
    run(25, 0);
    drive(1, 64'hcc, 9'h0cc);
    run(20, 0);

    // Drain
    n = 0;
    while ((pend.size() != 0 || outstanding) && n < 500) begin drive(0, '0, '0); n++; end
    chk("drain_timeout", 64'(n < 500), 64'd1);
    run(5, 0);
    chk("final_empty", 64'(pend.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
